uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_rx_fifo.sv | 322 ++++++++++++++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampling UART receiver with 2-of-3 majority bit voting,
// per-frame configuration shadowing and a first-word-fall-through receive
// FIFO whose entries carry the character plus parity/framing/break flags.
module uart_rx_fifo #(
   parameter int OSR   = 16,
   parameter int DEPTH = 4
) (
   input  logic                   MCLK,
   input  logic                   reset,
   input  logic                   sampleTick,
   input  logic                   enable,
   input  logic                   Rx,
   input  logic [1:0]             cfgBits,
   input  logic                   cfgPEN,
   input  logic                   cfgPAR,
   input  logic                   cfgMSB,
   input  logic                   cfgSPB,
   input  logic                   cfgKEEP,
   input  logic                   pop,
   input  logic                   clrOE,
   output logic [7:0]             rdData,
   output logic                   rdPE,
   output logic                   rdFE,
   output logic                   rdBRK,
   output logic                   empty,
   output logic                   full,
   output logic [$clog2(DEPTH):0] count,
   output logic                   overrun,
   output logic                   busy
);

   localparam int CW = $clog2(OSR);
   localparam int AW = $clog2(DEPTH);
   localparam int EW = 11;                 // {brk, fe, pe, data[7:0]}

   localparam int S0_I   = OSR / 2 - 1;
   localparam int S1_I   = OSR / 2;
   localparam int S2_I   = OSR / 2 + 1;
   localparam int LAST_I = OSR - 1;

   localparam logic [CW-1:0] TICK_S0   = S0_I[CW-1:0];
   localparam logic [CW-1:0] TICK_S1   = S1_I[CW-1:0];
   localparam logic [CW-1:0] TICK_S2   = S2_I[CW-1:0];
   localparam logic [CW-1:0] TICK_LAST = LAST_I[CW-1:0];
   localparam logic [AW:0]   DEPTH_CNT = DEPTH[AW:0];
   localparam logic [AW:0]   CNT_ONE   = {{AW{1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP1,
      STOP2
   } state_t;

   // ------------------------------------------------------------------
   // Line synchronizer
   // ------------------------------------------------------------------
   logic rx_meta_q;
   logic rx_sync_q;

   // Two flops on the asynchronous serial line; both idle high.
   always_ff @(posedge MCLK or posedge reset) begin
      if (reset) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
      end else begin
         rx_meta_q <= Rx;
         rx_sync_q <= rx_meta_q;
      end
   end

   // ------------------------------------------------------------------
   // Receive state machine
   // ------------------------------------------------------------------
   state_t          state_q;
   logic [CW-1:0]   tick_q;
   logic [2:0]      bit_cnt_q;
   logic            s0_q;
   logic            s1_q;
   logic [7:0]      data_q;
   logic            par_acc_q;
   logic            zero_q;
   logic            pe_q;
   logic            fe_q;
   logic            busy_q;
   logic            push_q;
   logic [EW-1:0]   push_entry_q;

   // Configuration captured at the start bit so mid-frame changes are ignored.
   logic [1:0]      bits_s_q;
   logic            pen_s_q;
   logic            par_s_q;
   logic            msb_s_q;
   logic            spb_s_q;
   logic            keep_s_q;

   logic            vote;
   logic            at_s2;
   logic            tick_wrap;
   logic [2:0]      len_m1;
   logic [2:0]      bit_pos;
   state_t          after_data;
   state_t          after_parity;

   // The third sample is taken live from the synchronizer at the vote tick.
   assign vote      = (s0_q & s1_q) | (s0_q & rx_sync_q) | (s1_q & rx_sync_q);
   assign at_s2     = (tick_q == TICK_S2);
   assign tick_wrap = (tick_q == TICK_LAST);
   assign len_m1    = {1'b0, bits_s_q} + 3'd4;
   // MSB-first frames fill the character from the top of its own width down.
   assign bit_pos   = msb_s_q ? (len_m1 - bit_cnt_q) : bit_cnt_q;

   assign after_parity = spb_s_q ? STOP2 : STOP1;
   assign after_data   = pen_s_q ? PARITY : after_parity;

   // Frame sequencing, bit voting, flag accumulation and push request.
   always_ff @(posedge MCLK or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         tick_q       <= '0;
         bit_cnt_q    <= '0;
         s0_q         <= 1'b1;
         s1_q         <= 1'b1;
         data_q       <= '0;
         par_acc_q    <= 1'b0;
         zero_q       <= 1'b1;
         pe_q         <= 1'b0;
         fe_q         <= 1'b0;
         busy_q       <= 1'b0;
         push_q       <= 1'b0;
         push_entry_q <= '0;
         bits_s_q     <= '0;
         pen_s_q      <= 1'b0;
         par_s_q      <= 1'b0;
         msb_s_q      <= 1'b0;
         spb_s_q      <= 1'b0;
         keep_s_q     <= 1'b0;
      end else begin
         push_q <= 1'b0;
         if (!enable) begin
            // Abandon any partial frame; FIFO contents are left alone.
            state_q <= IDLE;
            tick_q  <= '0;
            busy_q  <= 1'b0;
         end else if (sampleTick) begin
            if (state_q == IDLE) begin
               if (!rx_sync_q) begin
                  state_q   <= START;
                  busy_q    <= 1'b1;
                  tick_q    <= '0;
                  bit_cnt_q <= '0;
                  data_q    <= '0;
                  par_acc_q <= 1'b0;
                  zero_q    <= 1'b1;
                  pe_q      <= 1'b0;
                  fe_q      <= 1'b0;
                  bits_s_q  <= cfgBits;
                  pen_s_q   <= cfgPEN;
                  par_s_q   <= cfgPAR;
                  msb_s_q   <= cfgMSB;
                  spb_s_q   <= cfgSPB;
                  keep_s_q  <= cfgKEEP;
               end
            end else begin
               tick_q <= tick_wrap ? '0 : tick_q + 1'b1;
               if (tick_q == TICK_S0) begin
                  s0_q <= rx_sync_q;
               end
               if (tick_q == TICK_S1) begin
                  s1_q <= rx_sync_q;
               end
               case (state_q)
                  START: begin
                     if (at_s2 && vote) begin
                        // Line went back high: treat as noise.
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        tick_q  <= '0;
                     end else if (tick_wrap) begin
                        state_q <= DATA;
                     end
                  end
                  DATA: begin
                     if (at_s2) begin
                        data_q[bit_pos] <= vote;
                        par_acc_q       <= par_acc_q ^ vote;
                        zero_q          <= zero_q & ~vote;
                     end
                     if (tick_wrap) begin
                        if (bit_cnt_q == len_m1) begin
                           state_q   <= after_data;
                           bit_cnt_q <= '0;
                        end else begin
                           bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                     end
                  end
                  PARITY: begin
                     if (at_s2) begin
                        // Even wants total XOR 0, odd wants 1.
                        pe_q   <= par_acc_q ^ vote ^ ~par_s_q;
                        zero_q <= zero_q & ~vote;
                     end
                     if (tick_wrap) begin
                        state_q <= after_parity;
                     end
                  end
                  STOP2: begin
                     if (at_s2 && !vote) begin
                        fe_q <= 1'b1;
                     end
                     if (tick_wrap) begin
                        state_q <= STOP1;
                     end
                  end
                  STOP1: begin
                     // Finish at the vote so the next start edge is not missed.
                     if (at_s2) begin
                        state_q      <= IDLE;
                        busy_q       <= 1'b0;
                        tick_q       <= '0;
                        push_q       <= keep_s_q | ~(pe_q | fe_q | ~vote);
                        push_entry_q <= {zero_q & ~vote, fe_q | ~vote, pe_q, data_q};
                     end
                  end
                  default: begin
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                     tick_q  <= '0;
                  end
               endcase
            end
         end
      end
   end

   assign busy = busy_q;

   // ------------------------------------------------------------------
   // Receive FIFO (first-word-fall-through)
   // ------------------------------------------------------------------
   logic [EW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [AW:0]   count_q;
   logic          overrun_q;
   logic [AW-1:0] wr_ptr_d;
   logic [AW-1:0] rd_ptr_d;
   logic [AW:0]   count_d;
   logic          overrun_d;
   logic          empty_w;
   logic          full_w;
   logic          do_pop;
   logic          do_push;
   logic [EW-1:0] head;

   assign empty_w = (count_q == '0);
   assign full_w  = (count_q == DEPTH_CNT);
   assign do_pop  = pop & ~empty_w;
   // A pop in the same cycle frees the slot a full FIFO needs.
   assign do_push = push_q & (~full_w | do_pop);

   // Next-state for pointers, occupancy and the sticky overrun flag.
   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      overrun_d = overrun_q;
      if (do_push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (do_push && !do_pop) begin
         count_d = count_q + CNT_ONE;
      end else if (do_pop && !do_push) begin
         count_d = count_q - CNT_ONE;
      end
      // Setting wins over clearing when both happen together.
      if (push_q && !do_push) begin
         overrun_d = 1'b1;
      end else if (clrOE) begin
         overrun_d = 1'b0;
      end
   end

   // FIFO bookkeeping registers.
   always_ff @(posedge MCLK or posedge reset) begin
      if (reset) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         overrun_q <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         overrun_q <= overrun_d;
      end
   end

   // Storage write; contents need no reset because reads are gated by empty.
   always_ff @(posedge MCLK) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= push_entry_q;
      end
   end

   assign head    = mem_q[rd_ptr_q];
   assign rdData  = empty_w ? 8'h00 : head[7:0];
   assign rdPE    = ~empty_w & head[8];
   assign rdFE    = ~empty_w & head[9];
   assign rdBRK   = ~empty_w & head[10];
   assign empty   = empty_w;
   assign full    = full_w;
   assign count   = count_q;
   assign overrun = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo (OSR=16, DEPTH=4): directed frames
// for the key behaviours followed by randomized frames, all compared
// against a queue-based model of received characters.
module tb_uart_rx_fifo;

   localparam int OSR   = 16;
   localparam int DEPTH = 4;

   logic       MCLK;
   logic       reset;
   logic       sampleTick;
   logic       enable;
   logic       Rx;
   logic [1:0] cfgBits;
   logic       cfgPEN, cfgPAR, cfgMSB, cfgSPB, cfgKEEP;
   logic       pop;
   logic       clrOE;
   logic [7:0] rdData;
   logic       rdPE, rdFE, rdBRK;
   logic       empty, full;
   logic [2:0] count;
   logic       overrun;
   logic       busy;

   uart_rx_fifo #(.OSR(OSR), .DEPTH(DEPTH)) dut (
      .MCLK(MCLK), .reset(reset), .sampleTick(sampleTick), .enable(enable),
      .Rx(Rx), .cfgBits(cfgBits), .cfgPEN(cfgPEN), .cfgPAR(cfgPAR),
      .cfgMSB(cfgMSB), .cfgSPB(cfgSPB), .cfgKEEP(cfgKEEP), .pop(pop),
      .clrOE(clrOE), .rdData(rdData), .rdPE(rdPE), .rdFE(rdFE),
      .rdBRK(rdBRK), .empty(empty), .full(full), .count(count),
      .overrun(overrun), .busy(busy)
   );

   typedef struct packed {
      logic       brk;
      logic       fe;
      logic       pe;
      logic [7:0] data;
   } ent_t;

   ent_t exp_q[$];
   logic exp_ovr;
   int   checks = 0;
   int   errors = 0;

   initial begin
      MCLK = 1'b0;
      forever #5 MCLK = ~MCLK;
   end

   // One-cycle tick every second clock.
   initial begin
      sampleTick = 1'b0;
      forever begin
         @(negedge MCLK);
         sampleTick = ~sampleTick;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   task automatic tick_wait(input int n);
      for (int i = 0; i < n; i++) begin
         do @(posedge MCLK); while (sampleTick !== 1'b1);
      end
      #1;
   endtask

   // Full comparison of FIFO status and head entry against the model.
   task automatic check_state(input string tag);
      ent_t h;
      h = (exp_q.size() > 0) ? exp_q[0] : '0;
      check({tag, ".count"},   32'(count),   32'(exp_q.size()));
      check({tag, ".empty"},   32'(empty),   32'(exp_q.size() == 0));
      check({tag, ".full"},    32'(full),    32'(exp_q.size() == DEPTH));
      check({tag, ".overrun"}, 32'(overrun), 32'(exp_ovr));
      check({tag, ".busy"},    32'(busy),    32'(0));
      check({tag, ".rdData"},  32'(rdData),  32'(h.data));
      check({tag, ".rdPE"},    32'(rdPE),    32'(h.pe));
      check({tag, ".rdFE"},    32'(rdFE),    32'(h.fe));
      check({tag, ".rdBRK"},   32'(rdBRK),   32'(h.brk));
      $display("txn %s: count=%0d head=0x%02h pe=%b fe=%b brk=%b ovr=%b",
               tag, count, rdData, rdPE, rdFE, rdBRK, overrun);
   endtask

   // Drive one frame using the current cfg* settings, then idle two bit times.
   // bad_stop[0] corrupts the final stop bit, bad_stop[1] the first of two.
   task automatic send_frame(input logic [7:0] d, input logic bad_par,
                             input logic [1:0] bad_stop, input int glitch_bit);
      int   len;
      logic par;
      logic b;
      len = int'(cfgBits) + 5;
      par = 1'b0;
      Rx = 1'b0;
      tick_wait(OSR);
      for (int i = 0; i < len; i++) begin
         b = cfgMSB ? d[len-1-i] : d[i];
         par ^= b;
         Rx = b;
         if (i == glitch_bit) begin
            tick_wait(OSR/2);
            Rx = ~b;
            tick_wait(1);
            Rx = b;
            tick_wait(OSR/2 - 1);
         end else begin
            tick_wait(OSR);
         end
      end
      if (cfgPEN) begin
         Rx = par ^ ~cfgPAR ^ bad_par;
         tick_wait(OSR);
      end
      if (cfgSPB) begin
         Rx = ~bad_stop[1];
         tick_wait(OSR);
      end
      Rx = ~bad_stop[0];
      tick_wait(OSR);
      Rx = 1'b1;
      tick_wait(2 * OSR);
   endtask

   // Reference: what a completed frame should do to the FIFO contents.
   task automatic model_frame(input logic [7:0] d, input logic bad_par,
                              input logic [1:0] bad_stop, input logic sp, input logic sc);
      int         len;
      logic [7:0] mask;
      logic       pbit;
      ent_t       e;
      len    = int'(cfgBits) + 5;
      mask   = 8'((1 << len) - 1);
      e.data = d & mask;
      pbit   = (^e.data) ^ ~cfgPAR ^ bad_par;
      e.pe   = cfgPEN & bad_par;
      e.fe   = bad_stop[0] | (cfgSPB & bad_stop[1]);
      e.brk  = bad_stop[0] && (e.data == 8'h00) && (!cfgPEN || pbit == 1'b0);
      if (sp && exp_q.size() > 0) void'(exp_q.pop_front());
      if (sc) exp_ovr = 1'b0;
      if (!(e.pe | e.fe) || cfgKEEP) begin
         if (exp_q.size() < DEPTH) exp_q.push_back(e);
         else exp_ovr = 1'b1;
      end
   endtask

   task automatic do_pop(input string tag);
      pop = 1'b1;
      @(posedge MCLK);
      #1;
      pop = 1'b0;
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      check_state(tag);
   endtask

   // Send an 8-bit frame and strobe pop/clrOE in the cycle its push lands.
   task automatic send_strobe(input logic [7:0] d, input logic sp, input logic sc);
      int guard;
      guard = 0;
      fork
         send_frame(d, 1'b0, 2'b00, -1);
         begin
            while (busy !== 1'b1 && guard < 5000) begin @(negedge MCLK); guard++; end
            while (busy !== 1'b0 && guard < 5000) begin @(negedge MCLK); guard++; end
            pop   = sp;
            clrOE = sc;
            @(negedge MCLK);
            pop   = 1'b0;
            clrOE = 1'b0;
         end
      join
      check("strobe_wait_in_budget", 32'(guard < 5000), 32'(1));
      model_frame(d, 1'b0, 2'b00, sp, sc);
   endtask

   task automatic cfg_8n1(input logic keep);
      cfgBits = 2'b11; cfgPEN = 1'b0; cfgPAR = 1'b0;
      cfgMSB = 1'b0; cfgSPB = 1'b0; cfgKEEP = keep;
   endtask

   initial begin
      logic [7:0] d;
      logic       bp;
      logic [1:0] bs;
      ent_t       brk_e;

      reset = 1'b1; enable = 1'b1; Rx = 1'b1; pop = 1'b0; clrOE = 1'b0;
      cfg_8n1(1'b0);
      exp_ovr = 1'b0;
      repeat (4) @(posedge MCLK);
      #1;
      check_state("reset");
      reset = 1'b0;
      tick_wait(2 * OSR);

      // 8N1, 0xA5
      send_frame(8'hA5, 1'b0, 2'b00, -1);
      model_frame(8'hA5, 1'b0, 2'b00, 1'b0, 1'b0);
      check_state("8N1_A5");
      do_pop("8N1_A5_pop");

      // 7E2 MSB-first with corrupted parity, discarded then kept
      cfgBits = 2'b10; cfgPEN = 1'b1; cfgPAR = 1'b1; cfgMSB = 1'b1; cfgSPB = 1'b1;
      cfgKEEP = 1'b0;
      send_frame(8'h35, 1'b1, 2'b00, -1);
      model_frame(8'h35, 1'b1, 2'b00, 1'b0, 1'b0);
      check_state("7E2_bad_par_drop");
      cfgKEEP = 1'b1;
      send_frame(8'h35, 1'b1, 2'b00, -1);
      model_frame(8'h35, 1'b1, 2'b00, 1'b0, 1'b0);
      check_state("7E2_bad_par_keep");
      do_pop("7E2_pop");

      // False start: line low for 4 ticks only
      cfg_8n1(1'b0);
      Rx = 1'b0;
      tick_wait(4);
      Rx = 1'b1;
      check("false_start_busy", 32'(busy), 32'(1));
      tick_wait(OSR);
      check_state("false_start_idle");

      // Single-tick glitch in the middle of data bit 3
      send_frame(8'h5A, 1'b0, 2'b00, 3);
      model_frame(8'h5A, 1'b0, 2'b00, 1'b0, 1'b0);
      check_state("glitch_5A");
      do_pop("glitch_pop");

      // Break: 12 bit times low, then receiver disabled mid next frame
      cfg_8n1(1'b1);
      Rx = 1'b0;
      tick_wait(12 * OSR);
      brk_e = '{brk: 1'b1, fe: 1'b1, pe: 1'b0, data: 8'h00};
      exp_q.push_back(brk_e);
      check("break.count", 32'(count), 32'(1));
      check("break.rdData", 32'(rdData), 32'(0));
      check("break.rdFE", 32'(rdFE), 32'(1));
      check("break.rdBRK", 32'(rdBRK), 32'(1));
      check("break.rdPE", 32'(rdPE), 32'(0));
      enable = 1'b0;
      @(posedge MCLK);
      #1;
      check("disable_busy", 32'(busy), 32'(0));
      Rx = 1'b1;
      tick_wait(2 * OSR);
      enable = 1'b1;
      tick_wait(2 * OSR);
      check_state("break_after_disable");
      do_pop("break_pop");

      // Overrun sequence
      cfg_8n1(1'b0);
      for (int v = 1; v <= 5; v++) begin
         send_frame(8'(v), 1'b0, 2'b00, -1);
         model_frame(8'(v), 1'b0, 2'b00, 1'b0, 1'b0);
         check_state($sformatf("fill_%0d", v));
      end
      do_pop("ovr_pop_head01");
      clrOE = 1'b1;
      @(posedge MCLK);
      #1;
      clrOE = 1'b0;
      exp_ovr = 1'b0;
      check_state("clrOE");
      send_frame(8'h06, 1'b0, 2'b00, -1);
      model_frame(8'h06, 1'b0, 2'b00, 1'b0, 1'b0);
      check_state("refill_06");
      send_strobe(8'h07, 1'b0, 1'b1);
      check_state("overrun_set_vs_clr");
      send_strobe(8'h08, 1'b1, 1'b0);
      check_state("push_pop_full");
      while (exp_q.size() > 0) do_pop("drain");

      // Reset in the middle of a frame
      send_frame(8'h11, 1'b0, 2'b00, -1);
      model_frame(8'h11, 1'b0, 2'b00, 1'b0, 1'b0);
      send_frame(8'h22, 1'b0, 2'b00, -1);
      model_frame(8'h22, 1'b0, 2'b00, 1'b0, 1'b0);
      check_state("pre_reset");
      Rx = 1'b0;
      tick_wait(OSR);
      for (int i = 0; i < 4; i++) begin
         Rx = i[0];
         tick_wait(OSR);
      end
      check("mid_frame_busy", 32'(busy), 32'(1));
      reset = 1'b1;
      #2;
      exp_q.delete();
      exp_ovr = 1'b0;
      check_state("reset_mid_frame");
      Rx = 1'b1;
      repeat (3) @(posedge MCLK);
      #1;
      reset = 1'b0;
      tick_wait(2 * OSR);
      send_frame(8'h3C, 1'b0, 2'b00, -1);
      model_frame(8'h3C, 1'b0, 2'b00, 1'b0, 1'b0);
      check_state("after_reset_3C");
      do_pop("after_reset_pop");

      // Randomized frames with random formats, errors, pops and clears
      for (int n = 0; n < 30; n++) begin
         cfgBits = 2'($urandom_range(0, 3));
         cfgPEN  = 1'($urandom_range(0, 1));
         cfgPAR  = 1'($urandom_range(0, 1));
         cfgMSB  = 1'($urandom_range(0, 1));
         cfgSPB  = 1'($urandom_range(0, 1));
         cfgKEEP = 1'($urandom_range(0, 1));
         d  = 8'($urandom);
         bp = cfgPEN & ($urandom_range(0, 3) == 0);
         bs = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         if (!cfgSPB) bs[1] = 1'b0;
         send_frame(d, bp, bs, -1);
         model_frame(d, bp, bs, 1'b0, 1'b0);
         check_state($sformatf("rnd_%0d", n));
         if ($urandom_range(0, 2) != 0) do_pop($sformatf("rnd_pop_%0d", n));
         if ($urandom_range(0, 5) == 0) begin
            clrOE = 1'b1;
            @(posedge MCLK);
            #1;
            clrOE = 1'b0;
            exp_ovr = 1'b0;
            check_state($sformatf("rnd_clr_%0d", n));
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
